// File: rtl/vram_write_sched_pkg.sv
// Shared definitions for the video memory write scheduler: memory selects,
// default depths, FSM states and the per-memory depth lookup.
package vram_write_sched_pkg;

    localparam int unsigned DEF_PAL_DEPTH  = 16;
    localparam int unsigned DEF_TILE_DEPTH = 64;
    localparam int unsigned DEF_MAP_DEPTH  = 1200;
    localparam int unsigned DEF_ADDR_W     = 11;
    localparam int unsigned DEF_DATA_W     = 64;

    localparam logic [1:0] SEL_PAL  = 2'd0;
    localparam logic [1:0] SEL_TILE = 2'd1;
    localparam logic [1:0] SEL_PMAP = 2'd2;
    localparam logic [1:0] SEL_TMAP = 2'd3;

    typedef enum logic [2:0] {
        ST_CLR_PAL,
        ST_CLR_TILE,
        ST_CLR_PMAP,
        ST_CLR_TMAP,
        ST_IDLE,
        ST_FILL
    } sched_state_t;

    // Both map memories share one depth.
    function automatic int unsigned depth_of(input logic [1:0] sel,
                                             input int unsigned pal_depth,
                                             input int unsigned tile_depth,
                                             input int unsigned map_depth);
        case (sel)
            SEL_PAL:  return pal_depth;
            SEL_TILE: return tile_depth;
            default:  return map_depth;
        endcase
    endfunction

endpackage

// File: rtl/vram_write_sched_if.sv
// CPU request, fill command and memory write port of the scheduler,
// bundled so the requester side and the scheduler side each see one modport.
interface vram_write_sched_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 64
);
    logic              vblank;
    logic              cpu_req;
    logic [1:0]        cpu_sel;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ack;
    logic              cpu_err;
    logic              fill_start;
    logic [1:0]        fill_sel;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_count;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic              fill_done;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  vblank, cpu_req, cpu_sel, cpu_addr, cpu_data,
               fill_start, fill_sel, fill_base, fill_count, fill_value,
        output cpu_ack, cpu_err, busy, fill_done,
               wr_en, wr_sel, wr_addr, wr_data
    );

    modport master (
        output vblank, cpu_req, cpu_sel, cpu_addr, cpu_data,
               fill_start, fill_sel, fill_base, fill_count, fill_value,
        input  cpu_ack, cpu_err, busy, fill_done,
               wr_en, wr_sel, wr_addr, wr_data
    );
endinterface

// File: rtl/vram_fill_counter.sv
// Address / remaining-count pair shared by the clear sweep and the bulk fill.
// The remaining count saturates at zero so the clear sweep may step it freely.
module vram_fill_counter #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              zero
);
    logic [ADDR_W:0] remaining;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr;
            remaining <= load_count;
        end else if (step) begin
            addr <= addr + ADDR_W'(1);
            if (remaining != '0)
                remaining <= remaining - (ADDR_W + 1)'(1);
        end
    end

    assign zero = (remaining == '0);

endmodule

// File: rtl/vram_write_sched.sv
// Single registered write port for the picture memories: post-reset clear,
// bulk fill and single-word CPU writes, optionally confined to vblank.
module vram_write_sched
    import vram_write_sched_pkg::*;
#(
    parameter int unsigned PAL_DEPTH  = DEF_PAL_DEPTH,
    parameter int unsigned TILE_DEPTH = DEF_TILE_DEPTH,
    parameter int unsigned MAP_DEPTH  = DEF_MAP_DEPTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter bit          BLANK_ONLY = 1'b0
) (
    input logic               clk,
    input logic               reset,
    vram_write_sched_if.slave bus
);
    localparam int unsigned CW = ADDR_W + 1;

    function automatic logic [ADDR_W:0] depth_w(input logic [1:0] sel);
        return CW'(depth_of(sel, PAL_DEPTH, TILE_DEPTH, MAP_DEPTH));
    endfunction

    sched_state_t      state;
    logic              last_cpu;
    logic [1:0]        fill_sel_q;
    logic [DATA_W-1:0] fill_value_q;

    logic              win;
    logic              cpu_ok;
    logic              cpu_oor;
    logic              fill_ok;
    logic              cpu_grant;
    logic              fill_grant;
    logic              clr_write;
    logic              clr_last;
    logic [1:0]        clr_sel;
    logic [ADDR_W:0]   fill_depth;
    logic [ADDR_W:0]   fill_room;
    logic [ADDR_W:0]   fill_clip;

    logic              cnt_load;
    logic              cnt_step;
    logic [ADDR_W-1:0] cnt_load_addr;
    logic [ADDR_W:0]   cnt_load_count;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_zero;

    vram_fill_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_addr  (cnt_load_addr),
        .load_count (cnt_load_count),
        .step       (cnt_step),
        .addr       (cnt_addr),
        .zero       (cnt_zero)
    );

    assign win     = !BLANK_ONLY || bus.vblank;
    // A visible ack means this request was just consumed; never grant it twice.
    assign cpu_ok  = bus.cpu_req && win && !bus.cpu_ack;
    assign cpu_oor = ({1'b0, bus.cpu_addr} >= depth_w(bus.cpu_sel));
    assign fill_ok = win && !cnt_zero;

    // Fill length is clipped to the memory end so the address never wraps.
    assign fill_depth = depth_w(bus.fill_sel);
    assign fill_room  = ({1'b0, bus.fill_base} >= fill_depth) ? '0
                                                              : fill_depth - {1'b0, bus.fill_base};
    assign fill_clip  = (bus.fill_count < fill_room) ? bus.fill_count : fill_room;

    assign clr_last = ({1'b0, cnt_addr} == depth_w(clr_sel) - CW'(1));

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        clr_sel        = SEL_PAL;
        clr_write      = 1'b0;
        cpu_grant      = 1'b0;
        fill_grant     = 1'b0;
        cnt_load       = 1'b0;
        cnt_step       = 1'b0;
        cnt_load_addr  = '0;
        cnt_load_count = '0;
        case (state)
            ST_CLR_PAL, ST_CLR_TILE, ST_CLR_PMAP, ST_CLR_TMAP: begin
                case (state)
                    ST_CLR_TILE: clr_sel = SEL_TILE;
                    ST_CLR_PMAP: clr_sel = SEL_PMAP;
                    ST_CLR_TMAP: clr_sel = SEL_TMAP;
                    default:     clr_sel = SEL_PAL;
                endcase
                clr_write = 1'b1;
                cnt_load  = clr_last;
                cnt_step  = !clr_last;
            end
            ST_IDLE: begin
                cpu_grant = cpu_ok;
                if (bus.fill_start) begin
                    cnt_load       = 1'b1;
                    cnt_load_addr  = bus.fill_base;
                    cnt_load_count = fill_clip;
                end
            end
            ST_FILL: begin
                // Contention alternates; last_cpu starts low so the CPU goes first.
                if (!cnt_zero) begin
                    if (cpu_ok && (!fill_ok || !last_cpu))
                        cpu_grant = 1'b1;
                    else if (fill_ok)
                        fill_grant = 1'b1;
                end
                cnt_step = fill_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_CLR_PAL;
            last_cpu      <= 1'b0;
            fill_sel_q    <= SEL_PAL;
            fill_value_q  <= '0;
            bus.busy      <= 1'b1;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.fill_done <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.wr_sel    <= SEL_PAL;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
        end else begin
            bus.cpu_ack   <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.fill_done <= 1'b0;
            bus.wr_en     <= 1'b0;

            if (clr_write) begin
                bus.wr_en   <= 1'b1;
                bus.wr_sel  <= clr_sel;
                bus.wr_addr <= cnt_addr;
                bus.wr_data <= '0;
            end
            if (cpu_grant) begin
                bus.cpu_ack <= 1'b1;
                bus.cpu_err <= cpu_oor;
                bus.wr_en   <= !cpu_oor;
                bus.wr_sel  <= bus.cpu_sel;
                bus.wr_addr <= bus.cpu_addr;
                bus.wr_data <= bus.cpu_data;
                last_cpu    <= 1'b1;
            end
            if (fill_grant) begin
                bus.wr_en   <= 1'b1;
                bus.wr_sel  <= fill_sel_q;
                bus.wr_addr <= cnt_addr;
                bus.wr_data <= fill_value_q;
                last_cpu    <= 1'b0;
            end

            case (state)
                ST_CLR_PAL:  if (clr_last) state <= ST_CLR_TILE;
                ST_CLR_TILE: if (clr_last) state <= ST_CLR_PMAP;
                ST_CLR_PMAP: if (clr_last) state <= ST_CLR_TMAP;
                ST_CLR_TMAP: begin
                    if (clr_last) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.fill_start) begin
                        state        <= ST_FILL;
                        bus.busy     <= 1'b1;
                        fill_sel_q   <= bus.fill_sel;
                        fill_value_q <= bus.fill_value;
                        last_cpu     <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (cnt_zero) begin
                        state         <= ST_IDLE;
                        bus.busy      <= 1'b0;
                        bus.fill_done <= 1'b1;
                    end
                end
                default: state <= ST_CLR_PAL;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_sched.sv
// Directed bench for vram_write_sched: one instance without and one with the
// vblank-only write window, driven in lockstep from a single sequence.
module tb_vram_write_sched;
    localparam int CLR_TOTAL = 16 + 64 + 1200 + 1200;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    vram_write_sched_if #(.ADDR_W(11), .DATA_W(64)) if0 ();
    vram_write_sched_if #(.ADDR_W(11), .DATA_W(64)) if1 ();

    vram_write_sched #(.BLANK_ONLY(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    vram_write_sched #(.BLANK_ONLY(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full clear sweep on both instances; dut1 is offered a CPU request and a
    // fill command throughout, both of which must be ignored.
    task automatic run_clear(input string tag);
        int         bad0;
        int         bad1;
        int         acks1;
        logic [1:0] es;
        logic [10:0] ea;
        bad0 = 0; bad1 = 0; acks1 = 0;
        if1.vblank   = 1'b1;
        if1.cpu_req  = 1'b1;
        if1.cpu_sel  = 2'd2;
        if1.cpu_addr = 11'd7;
        if1.cpu_data = 64'h77;
        if1.fill_sel = 2'd0; if1.fill_base = 11'd0; if1.fill_count = 12'd4;
        for (int i = 0; i < CLR_TOTAL; i++) begin
            if1.fill_start = (i == 100);
            step();
            if (i < 16)        begin es = 2'd0; ea = 11'(i);        end
            else if (i < 80)   begin es = 2'd1; ea = 11'(i - 16);   end
            else if (i < 1280) begin es = 2'd2; ea = 11'(i - 80);   end
            else               begin es = 2'd3; ea = 11'(i - 1280); end
            if (!(if0.wr_en === 1'b1 && if0.wr_sel === es && if0.wr_addr === ea &&
                  if0.wr_data === 64'd0 && if0.busy === (i != CLR_TOTAL - 1))) bad0++;
            if (!(if1.wr_en === 1'b1 && if1.wr_sel === es && if1.wr_addr === ea &&
                  if1.wr_data === 64'd0 && if1.busy === (i != CLR_TOTAL - 1))) bad1++;
            if (if1.cpu_ack !== 1'b0 || if0.cpu_ack !== 1'b0) acks1++;
        end
        if1.cpu_req    = 1'b0;
        if1.fill_start = 1'b0;
        if1.vblank     = 1'b0;
        check({tag, "_seq_dut0"}, 64'(bad0), 64'd0);
        check({tag, "_seq_dut1"}, 64'(bad1), 64'd0);
        check({tag, "_no_ack"}, 64'(acks1), 64'd0);
        step();
        check({tag, "_after_wr_en0"}, 64'(if0.wr_en), 64'd0);
        check({tag, "_after_busy0"}, 64'(if0.busy), 64'd0);
        check({tag, "_after_busy1"}, 64'(if1.busy), 64'd0);
    endtask

    int          rng_sel  [4] = '{0, 0, 1, 2};
    int          rng_addr [4] = '{15, 16, 63, 1200};
    int          rng_err  [4] = '{0, 1, 0, 1};

    initial begin
        int bad;
        int acks;
        int fills;
        int found;
        int writes;

        reset = 1'b1;
        if0.vblank = 1'b0; if0.cpu_req = 1'b0; if0.cpu_sel = 2'd0; if0.cpu_addr = '0;
        if0.cpu_data = '0; if0.fill_start = 1'b0; if0.fill_sel = 2'd0; if0.fill_base = '0;
        if0.fill_count = '0; if0.fill_value = '0;
        if1.vblank = 1'b0; if1.cpu_req = 1'b0; if1.cpu_sel = 2'd0; if1.cpu_addr = '0;
        if1.cpu_data = '0; if1.fill_start = 1'b0; if1.fill_sel = 2'd0; if1.fill_base = '0;
        if1.fill_count = '0; if1.fill_value = '0;

        step();
        step();
        check("rst_busy",      64'(if0.busy),      64'd1);
        check("rst_wr_en",     64'(if0.wr_en),     64'd0);
        check("rst_wr_sel",    64'(if0.wr_sel),    64'd0);
        check("rst_wr_addr",   64'(if0.wr_addr),   64'd0);
        check("rst_wr_data",   if0.wr_data,        64'd0);
        check("rst_cpu_ack",   64'(if0.cpu_ack),   64'd0);
        check("rst_cpu_err",   64'(if0.cpu_err),   64'd0);
        check("rst_fill_done", 64'(if0.fill_done), 64'd0);
        reset = 1'b0;

        run_clear("clear1");

        // Single CPU write, request held across the ack cycle.
        if0.cpu_req = 1'b1; if0.cpu_sel = 2'd3; if0.cpu_addr = 11'd5; if0.cpu_data = 64'h2A;
        step();
        check("cpu_ack",     64'(if0.cpu_ack), 64'd1);
        check("cpu_err",     64'(if0.cpu_err), 64'd0);
        check("cpu_wr_en",   64'(if0.wr_en),   64'd1);
        check("cpu_wr_sel",  64'(if0.wr_sel),  64'd3);
        check("cpu_wr_addr", 64'(if0.wr_addr), 64'd5);
        check("cpu_wr_data", if0.wr_data,      64'h2A);
        step();
        check("cpu_held_no_reack", 64'(if0.cpu_ack), 64'd0);
        check("cpu_held_no_write", 64'(if0.wr_en),   64'd0);
        if0.cpu_req = 1'b0;
        step();
        check("cpu_released_ack", 64'(if0.cpu_ack), 64'd0);

        // Range boundaries: last legal address and first illegal one.
        for (int r = 0; r < 4; r++) begin
            if0.cpu_req  = 1'b1;
            if0.cpu_sel  = 2'(rng_sel[r]);
            if0.cpu_addr = 11'(rng_addr[r]);
            if0.cpu_data = 64'hC0DE_0000 + 64'(r);
            step();
            check("rng_ack",   64'(if0.cpu_ack), 64'd1);
            check("rng_err",   64'(if0.cpu_err), 64'(rng_err[r]));
            check("rng_wr_en", 64'(if0.wr_en),   64'(1 - rng_err[r]));
            if (rng_err[r] == 0) check("rng_wr_addr", 64'(if0.wr_addr), 64'(rng_addr[r]));
            if0.cpu_req = 1'b0;
            step();
            check("rng_ack_clear", 64'(if0.cpu_ack), 64'd0);
        end

        // Fill clipped at the map end, contending with a steady CPU request.
        if0.fill_start = 1'b1; if0.fill_sel = 2'd2; if0.fill_base = 11'd1195;
        if0.fill_count = 12'd10; if0.fill_value = 64'd7;
        step();
        if0.fill_start = 1'b0;
        check("fill_entry_busy",  64'(if0.busy),  64'd1);
        check("fill_entry_wr_en", 64'(if0.wr_en), 64'd0);
        if0.cpu_req = 1'b1; if0.cpu_sel = 2'd3; if0.cpu_addr = 11'd9; if0.cpu_data = 64'h55;
        if0.fill_base = 11'd0; if0.fill_count = 12'd3;
        bad = 0; acks = 0; fills = 0;
        for (int k = 0; k < 10; k++) begin
            if0.fill_start = (k == 3);
            step();
            if (k % 2 == 0) begin
                if (!(if0.cpu_ack === 1'b1 && if0.wr_en === 1'b1 && if0.wr_sel === 2'd3 &&
                      if0.wr_addr === 11'd9 && if0.wr_data === 64'h55)) bad++;
            end else begin
                if (!(if0.cpu_ack === 1'b0 && if0.wr_en === 1'b1 && if0.wr_sel === 2'd2 &&
                      if0.wr_addr === 11'(1195 + (k - 1) / 2) && if0.wr_data === 64'd7)) bad++;
            end
            if (if0.busy !== 1'b1 || if0.fill_done !== 1'b0) bad++;
            if (if0.cpu_ack === 1'b1) acks++;
            if (if0.wr_en === 1'b1 && if0.wr_sel === 2'd2) fills++;
        end
        if0.fill_start = 1'b0;
        check("fill_interleave", 64'(bad),   64'd0);
        check("fill_cpu_acks",   64'(acks),  64'd5);
        check("fill_writes",     64'(fills), 64'd5);
        step();
        check("fill_done_pulse", 64'(if0.fill_done), 64'd1);
        check("fill_done_no_wr", 64'(if0.wr_en),     64'd0);
        check("fill_done_busy",  64'(if0.busy),      64'd0);
        check("fill_done_ack",   64'(if0.cpu_ack),   64'd0);
        if0.cpu_req = 1'b0;
        step();
        check("fill_done_once",   64'(if0.fill_done), 64'd0);
        check("fill_not_restart", 64'(if0.busy),      64'd0);

        // Base past the end of the tile definitions: empty fill.
        if0.fill_start = 1'b1; if0.fill_sel = 2'd1; if0.fill_base = 11'd64; if0.fill_count = 12'd5;
        step();
        if0.fill_start = 1'b0;
        check("oob_fill_busy", 64'(if0.busy), 64'd1);
        step();
        check("oob_fill_done",  64'(if0.fill_done), 64'd1);
        check("oob_fill_no_wr", 64'(if0.wr_en),     64'd0);

        // Blank-only instance: CPU waits for vblank.
        if1.cpu_req = 1'b1; if1.cpu_sel = 2'd1; if1.cpu_addr = 11'd3; if1.cpu_data = 64'h1234;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (if1.cpu_ack !== 1'b0 || if1.wr_en !== 1'b0) acks++;
        end
        check("blank_cpu_blocked", 64'(acks), 64'd0);
        if1.vblank = 1'b1;
        step();
        check("blank_cpu_ack",     64'(if1.cpu_ack), 64'd1);
        check("blank_cpu_wr_en",   64'(if1.wr_en),   64'd1);
        check("blank_cpu_wr_addr", 64'(if1.wr_addr), 64'd3);
        check("blank_cpu_wr_data", if1.wr_data,      64'h1234);
        if1.cpu_req = 1'b0;
        if1.vblank  = 1'b0;

        // Zero-length fill.
        if1.fill_start = 1'b1; if1.fill_sel = 2'd0; if1.fill_base = 11'd2;
        if1.fill_count = 12'd0; if1.fill_value = 64'd9;
        step();
        if1.fill_start = 1'b0;
        check("zero_fill_busy", 64'(if1.busy), 64'd1);
        step();
        check("zero_fill_done",  64'(if1.fill_done), 64'd1);
        check("zero_fill_no_wr", 64'(if1.wr_en),     64'd0);
        check("zero_fill_idle",  64'(if1.busy),      64'd0);

        // Fill clipped at the palette end and held off until vblank.
        if1.fill_start = 1'b1; if1.fill_sel = 2'd0; if1.fill_base = 11'd14;
        if1.fill_count = 12'd5; if1.fill_value = 64'hAB;
        step();
        if1.fill_start = 1'b0;
        writes = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (if1.wr_en !== 1'b0 || if1.busy !== 1'b1) writes++;
        end
        check("blank_fill_blocked", 64'(writes), 64'd0);
        if1.vblank = 1'b1;
        step();
        check("blank_fill_wr0_en",   64'(if1.wr_en),   64'd1);
        check("blank_fill_wr0_addr", 64'(if1.wr_addr), 64'd14);
        check("blank_fill_wr0_data", if1.wr_data,      64'hAB);
        step();
        check("blank_fill_wr1_addr", 64'(if1.wr_addr), 64'd15);
        step();
        check("blank_fill_done",  64'(if1.fill_done), 64'd1);
        check("blank_fill_no_wr", 64'(if1.wr_en),     64'd0);
        if1.vblank = 1'b0;

        // Reset in the middle of a tile-map fill.
        if0.fill_start = 1'b1; if0.fill_sel = 2'd3; if0.fill_base = 11'd0;
        if0.fill_count = 12'd2000; if0.fill_value = 64'hFF;
        step();
        if0.fill_start = 1'b0;
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            step();
            if (if0.wr_en === 1'b1 && if0.wr_addr === 11'd300) found = 1;
        end
        check("midfill_reached_300", 64'(found), 64'd1);
        reset = 1'b1;
        step();
        check("midfill_rst_wr_en", 64'(if0.wr_en),     64'd0);
        check("midfill_rst_busy",  64'(if0.busy),      64'd1);
        check("midfill_rst_done",  64'(if0.fill_done), 64'd0);
        reset = 1'b0;

        run_clear("clear2");

        writes = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (if0.wr_en !== 1'b0 || if0.busy !== 1'b0 || if0.fill_done !== 1'b0) writes++;
        end
        check("fill_not_resumed", 64'(writes), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
